// File: rtl/dmux_stream.sv
`default_nettype none
// dmux_stream: valid/ready stream demultiplexer into WAYS one-entry output
// registers, with broadcast and saturating out-of-range drop counting.
module dmux_stream #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SEL_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_bcast,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WAYS*WIDTH-1:0] out_data,
  output logic [WAYS-1:0]       out_valid,
  input  logic [WAYS-1:0]       out_ready,
  output logic                  drop_pulse,
  output logic [7:0]            drop_cnt
);

  localparam logic [SEL_W:0] WAYS_W = (SEL_W+1)'(WAYS);

  logic [WAYS-1:0] free;
  logic [WAYS-1:0] load;
  logic            sel_ok;
  logic            sel_free;
  logic            accept;
  logic            drop;

  // A channel can take a word if empty or being drained this same cycle.
  assign free   = ~out_valid | out_ready;
  assign sel_ok = {1'b0, in_sel} < WAYS_W;

  always_comb begin
    sel_free = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      if (in_sel == SEL_W'(k)) sel_free = free[k];
    end
  end

  // Out-of-range selects are always accepted so the source never stalls on them.
  assign in_ready = in_bcast ? (&free) : (sel_ok ? sel_free : 1'b1);
  assign accept   = in_valid && in_ready;
  assign drop     = accept && !in_bcast && !sel_ok;

  always_comb begin
    load = '0;
    for (int k = 0; k < WAYS; k++) begin
      load[k] = accept && (in_bcast || (sel_ok && (in_sel == SEL_W'(k))));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < WAYS; k++) begin
        if (load[k]) begin
          out_valid[k]               <= 1'b1;
          out_data[k*WIDTH +: WIDTH] <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      drop_pulse <= drop;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmux_stream.sv
`default_nettype none
// tb_dmux_stream: directed self-checking bench for dmux_stream, WAYS=8 and WAYS=6.
module tb_dmux_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // WAYS=8 instance
  logic [15:0]  a_data = '0;
  logic [2:0]   a_sel = '0;
  logic         a_bcast = 1'b0;
  logic         a_valid = 1'b0;
  logic         a_ready;
  logic [127:0] a_odata;
  logic [7:0]   a_ovalid;
  logic [7:0]   a_oready = 8'hFF;
  logic         a_pulse;
  logic [7:0]   a_cnt;

  // WAYS=6 instance
  logic [15:0]  b_data = '0;
  logic [2:0]   b_sel = '0;
  logic         b_bcast = 1'b0;
  logic         b_valid = 1'b0;
  logic         b_ready;
  logic [95:0]  b_odata;
  logic [5:0]   b_ovalid;
  logic [5:0]   b_oready = 6'h3F;
  logic         b_pulse;
  logic [7:0]   b_cnt;

  dmux_stream #(.WIDTH(16), .WAYS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .in_bcast(a_bcast),
    .in_valid(a_valid), .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid),
    .out_ready(a_oready), .drop_pulse(a_pulse), .drop_cnt(a_cnt)
  );

  dmux_stream #(.WIDTH(16), .WAYS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_bcast(b_bcast),
    .in_valid(b_valid), .in_ready(b_ready), .out_data(b_odata), .out_valid(b_ovalid),
    .out_ready(b_oready), .drop_pulse(b_pulse), .drop_cnt(b_cnt)
  );

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (a_ovalid !== 8'h00) $display("FAIL reset_valid got %h want 00", a_ovalid); else passes++;
    checks++; if (a_odata !== 128'h0) $display("FAIL reset_data got %h want 0", a_odata); else passes++;
    checks++; if ({b_pulse, b_cnt} !== 9'h0) $display("FAIL reset_drop got %h want 000", {b_pulse, b_cnt}); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unicast();
    a_oready = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a_sel = 3'(k); a_data = 16'h1000 + 16'(k); a_valid = 1'b1;
      #1;
      checks++; if (a_ready !== 1'b1) $display("FAIL uni_ready ch%0d got %b want 1", k, a_ready); else passes++;
      after_edge();
      checks++; if (a_ovalid !== 8'(1 << k)) $display("FAIL uni_valid ch%0d got %h want %h", k, a_ovalid, 8'(1 << k)); else passes++;
      checks++; if (a_odata[k*16 +: 16] !== 16'h1000 + 16'(k)) $display("FAIL uni_data ch%0d got %h want %h", k, a_odata[k*16 +: 16], 16'h1000 + 16'(k)); else passes++;
    end
    @(negedge clk);
    a_valid = 1'b0;
    after_edge();
    checks++; if (a_ovalid !== 8'h00) $display("FAIL uni_drain got %h want 00", a_ovalid); else passes++;
    for (int k = 0; k < 8; k++) begin
      checks++; if (a_odata[k*16 +: 16] !== 16'h1000 + 16'(k)) $display("FAIL uni_hold ch%0d got %h want %h", k, a_odata[k*16 +: 16], 16'h1000 + 16'(k)); else passes++;
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    a_oready = 8'hF7;
    a_sel = 3'd3; a_data = 16'hAAAA; a_valid = 1'b1;
    after_edge();
    checks++; if (a_ovalid !== 8'h08) $display("FAIL stall_load got %h want 08", a_ovalid); else passes++;
    @(negedge clk);
    a_data = 16'hBBBB;
    #1;
    checks++; if (a_ready !== 1'b0) $display("FAIL stall_ready got %b want 0", a_ready); else passes++;
    after_edge();
    checks++; if (a_odata[3*16 +: 16] !== 16'hAAAA) $display("FAIL stall_hold got %h want aaaa", a_odata[3*16 +: 16]); else passes++;
    @(negedge clk);
    a_sel = 3'd5; a_data = 16'hCCCC;
    #1;
    checks++; if (a_ready !== 1'b1) $display("FAIL stall_other_ready got %b want 1", a_ready); else passes++;
    after_edge();
    checks++; if (a_ovalid !== 8'h28) $display("FAIL stall_other_valid got %h want 28", a_ovalid); else passes++;
    checks++; if (a_odata[5*16 +: 16] !== 16'hCCCC) $display("FAIL stall_other_data got %h want cccc", a_odata[5*16 +: 16]); else passes++;
    @(negedge clk);
    a_sel = 3'd3; a_data = 16'hBBBB; a_oready = 8'hFF;
    #1;
    checks++; if (a_ready !== 1'b1) $display("FAIL release_ready got %b want 1", a_ready); else passes++;
    after_edge();
    checks++; if (a_ovalid !== 8'h08) $display("FAIL release_valid got %h want 08", a_ovalid); else passes++;
    checks++; if (a_odata[3*16 +: 16] !== 16'hBBBB) $display("FAIL release_data got %h want bbbb", a_odata[3*16 +: 16]); else passes++;
    @(negedge clk);
    a_valid = 1'b0;
    after_edge();
    checks++; if (a_ovalid !== 8'h00) $display("FAIL release_drain got %h want 00", a_ovalid); else passes++;
  endtask

  task automatic test_bcast();
    @(negedge clk);
    a_oready = 8'hFB;
    a_sel = 3'd2; a_data = 16'h1234; a_valid = 1'b1;
    after_edge();
    @(negedge clk);
    a_bcast = 1'b1; a_data = 16'h5A5A;
    #1;
    checks++; if (a_ready !== 1'b0) $display("FAIL bcast_blocked got %b want 0", a_ready); else passes++;
    after_edge();
    checks++; if (a_ovalid !== 8'h04) $display("FAIL bcast_wait_valid got %h want 04", a_ovalid); else passes++;
    checks++; if (a_odata[0 +: 16] !== 16'h1000) $display("FAIL bcast_wait_data got %h want 1000", a_odata[0 +: 16]); else passes++;
    @(negedge clk);
    a_oready = 8'hFF;
    #1;
    checks++; if (a_ready !== 1'b1) $display("FAIL bcast_ready got %b want 1", a_ready); else passes++;
    after_edge();
    checks++; if (a_ovalid !== 8'hFF) $display("FAIL bcast_valid got %h want ff", a_ovalid); else passes++;
    checks++; if (a_odata !== {8{16'h5A5A}}) $display("FAIL bcast_data got %h want all 5a5a", a_odata); else passes++;
    @(negedge clk);
    a_valid = 1'b0; a_bcast = 1'b0;
    after_edge();
    checks++; if (a_ovalid !== 8'h00) $display("FAIL bcast_drain got %h want 00", a_ovalid); else passes++;
  endtask

  task automatic test_drop();
    @(negedge clk);
    b_sel = 3'd6; b_data = 16'hDEAD; b_valid = 1'b1;
    #1;
    checks++; if (b_ready !== 1'b1) $display("FAIL drop_ready got %b want 1", b_ready); else passes++;
    after_edge();
    checks++; if ({b_pulse, b_cnt} !== {1'b1, 8'd1}) $display("FAIL drop_first got %h want 101", {b_pulse, b_cnt}); else passes++;
    @(negedge clk);
    b_sel = 3'd7;
    after_edge();
    checks++; if ({b_pulse, b_cnt} !== {1'b1, 8'd2}) $display("FAIL drop_second got %h want 102", {b_pulse, b_cnt}); else passes++;
    checks++; if ({b_ovalid, b_odata} !== 102'h0) $display("FAIL drop_no_load got %h want 0", {b_ovalid, b_odata}); else passes++;
    @(negedge clk);
    b_valid = 1'b0;
    after_edge();
    checks++; if ({b_pulse, b_cnt} !== {1'b0, 8'd2}) $display("FAIL drop_idle got %h want 002", {b_pulse, b_cnt}); else passes++;
    @(negedge clk);
    b_sel = 3'd6; b_valid = 1'b1;
    repeat (252) @(posedge clk);
    #1;
    checks++; if (b_cnt !== 8'd254) $display("FAIL drop_cnt254 got %0d want 254", b_cnt); else passes++;
    after_edge();
    checks++; if (b_cnt !== 8'd255) $display("FAIL drop_cnt255 got %0d want 255", b_cnt); else passes++;
    repeat (47) @(posedge clk);
    #1;
    checks++; if ({b_pulse, b_cnt} !== {1'b1, 8'd255}) $display("FAIL drop_sat got %h want 1ff", {b_pulse, b_cnt}); else passes++;
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a_oready = 8'hED;
    a_sel = 3'd1; a_data = 16'h1111; a_valid = 1'b1;
    after_edge();
    @(negedge clk);
    a_sel = 3'd4; a_data = 16'h4444;
    after_edge();
    checks++; if (a_ovalid !== 8'h12) $display("FAIL ar_pre_valid got %h want 12", a_ovalid); else passes++;
    @(negedge clk);
    a_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (a_ovalid !== 8'h00) $display("FAIL ar_valid got %h want 00", a_ovalid); else passes++;
    checks++; if (a_odata !== 128'h0) $display("FAIL ar_data got %h want 0", a_odata); else passes++;
    checks++; if ({b_pulse, b_cnt} !== 9'h0) $display("FAIL ar_drop got %h want 000", {b_pulse, b_cnt}); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    a_oready = 8'hFF;
    @(negedge clk);
    a_sel = 3'd1; a_data = 16'h7777; a_valid = 1'b1;
    after_edge();
    checks++; if (a_ovalid !== 8'h02) $display("FAIL ar_post_valid got %h want 02", a_ovalid); else passes++;
    checks++; if (a_odata[1*16 +: 16] !== 16'h7777) $display("FAIL ar_post_data got %h want 7777", a_odata[1*16 +: 16]); else passes++;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_stall();
    test_bcast();
    test_drop();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmux_stream.md
# dmux_stream

Parametrised, registered successor to the combinational 8-way demultiplexer: routes a valid/ready input stream of `WIDTH`-bit words to one of `WAYS` output channels selected per transfer, or to all channels at once in broadcast mode. Each channel owns a one-entry output register with its own valid/ready handshake, so a stalled channel never blocks traffic to the others. Transfers with an out-of-range select are dropped and counted. It sits between the CPU-side memory-mapped write path and the peripheral channel sinks.

## Interface
- `WIDTH`, 16, data word width in bits (≥1)
- `WAYS`, 8, number of output channels (2..16; need not be a power of two)
- `SEL_W`, `$clog2(WAYS)`, select width; derived, never overridden

- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `in_data`  in  WIDTH  input word
- `in_sel`  in  SEL_W  destination channel index
- `in_bcast`  in  1  1 = write word to every channel, `in_sel` ignored
- `in_valid`  in  1  input word present
- `in_ready`  out  1  block accepts the word this cycle (combinational)
- `out_data`  out  WAYS*WIDTH  channel k word at bits [k*WIDTH +: WIDTH]
- `out_valid`  out  WAYS  bit k = channel k register holds a word
- `out_ready`  in  WAYS  bit k = channel k sink consumes this cycle
- `drop_pulse`  out  1  one-cycle pulse, an out-of-range word was discarded
- `drop_cnt`  out  8  saturating count of discarded words

## Operation
- Channel k is "free" when `!out_valid[k] || out_ready[k]`.
- `in_ready`:
  - `in_bcast=1`: AND of free over all WAYS channels.
  - `in_bcast=0`, `in_sel < WAYS`: free of channel `in_sel`.
  - `in_bcast=0`, `in_sel >= WAYS`: 1 (word is sunk).
- Accept = `in_valid && in_ready`. On accept:
  - unicast valid sel: `out_data[sel]` ← `in_data`, `out_valid[sel]` ← 1.
  - broadcast: every channel loads `in_data`, every `out_valid` ← 1.
  - invalid sel: no channel changes; `drop_pulse` ← 1 next cycle; `drop_cnt` += 1, saturating at 255.
- Channel k not loaded: `out_valid[k]` ← 0 if `out_ready[k]`, else holds.
- `out_data[k]` changes only on load or reset; holds last word after drain.
- Simultaneous drain and load on the same channel: load wins, `out_valid[k]` stays 1, new word replaces old (no bubble).
- `out_ready[k]` with `out_valid[k]=0` is ignored.
- `in_data`/`in_sel`/`in_bcast` while `in_ready=0` have no effect; the source holds them until accepted.

## Timing
- Reset (`rst_n`=0, asynchronous): `out_valid`=0, `out_data`=0, `drop_pulse`=0, `drop_cnt`=0 immediately, regardless of `clk`; words in flight are lost. Released state is idle.
- Latency: word accepted at edge N is visible with `out_valid[k]=1` after edge N.
- Throughput: one word per cycle into any single channel whose sink holds `out_ready=1`.
- `drop_pulse` high for exactly the cycle after each dropped accept; back-to-back drops keep it high continuously.
- `in_ready` is combinational from `in_sel`, `in_bcast`, `out_valid`, `out_ready`; no combinational path from `in_valid` or `in_data` to any output.

## Test plan
- WAYS=8, WIDTH=16: reset, then unicast sel=0..7 with data 0x1000+k, all `out_ready`=1 → each `out_valid[k]` pulses one cycle after its accept, `out_data[k]`=0x1000+k, other channels untouched.
- Channel 3 stalled (`out_ready[3]`=0): write 0xAAAA to 3, then 0xBBBB to 3 and 0xCCCC to 5 → `in_ready`=0 while sel=3, source switching to sel=5 is accepted next cycle; releasing `out_ready[3]` the same cycle as the pending 0xBBBB write yields 0xBBBB with no gap in `out_valid[3]`.
- Broadcast 0x5A5A with `out_valid[2]`=1 and `out_ready[2]`=0 → `in_ready`=0; after channel 2 drains, accept → all 8 `out_valid`=1, all `out_data`=0x5A5A.
- WAYS=6: sel=6 and sel=7 words → `in_ready`=1, no channel loads, `drop_pulse` high two consecutive cycles, `drop_cnt`=2; 300 drops → `drop_cnt`=255.
- Reset asserted mid-stream between clock edges with channels 1 and 4 holding data → all outputs 0 before the next edge; after release first write to channel 1 appears after one cycle.
